// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: load sizes and the hard-wired zero register.
package writeback_stage_pkg;

    localparam logic [1:0] LS_WORD  = 2'b00;
    localparam logic [1:0] LS_BYTE  = 2'b01;
    localparam logic [1:0] LS_HALF  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_stage_load_align.sv
// load_align: picks a byte or halfword out of a loaded word and sign/zero-extends it.
// Sizes 00 and 11 both pass the full word through.
module load_align
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_bit;

    always_comb begin
        byte_v = data_in[7:0];
        case (byte_off)
            2'd0:    byte_v = data_in[7:0];
            2'd1:    byte_v = data_in[15:8];
            2'd2:    byte_v = data_in[23:16];
            default: byte_v = data_in[31:24];
        endcase
        half_v = byte_off[1] ? data_in[31:16] : data_in[15:0];
    end

    always_comb begin
        data_out = data_in;
        sign_bit = 1'b0;
        case (load_size)
            LS_BYTE: begin
                sign_bit = ~load_unsigned & byte_v[7];
                data_out = {{(DATA_W-8){sign_bit}}, byte_v};
            end
            LS_HALF: begin
                sign_bit = ~load_unsigned & half_v[15];
                data_out = {{(DATA_W-16){sign_bit}}, half_v};
            end
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline latch: captures the memory-stage result, drives the register-file write
// and counts retired instructions. Define WB_SUBWORD_EN for byte/halfword load extraction.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    input  logic [1:0]        byte_off_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [4:0]        rd_in,
    output logic              r_write,
    output logic [4:0]        rd_write,
    output logic [DATA_W-1:0] w_data,
    output logic [CNT_W-1:0]  retired
);

    logic              valid_q, valid_d;
    logic              fresh_q, fresh_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              capture;
    logic [DATA_W-1:0] load_value;

    assign capture = !stall && !flush;

    always_comb begin
        valid_d      = valid_q;
        fresh_d      = 1'b0;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        retired_d    = retired_q;
        // Flush only drops the valid bit; the stale payload is harmless once invalid.
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d      = valid_in;
            fresh_d      = valid_in;
            reg_write_d  = reg_write_in;
            mem_to_reg_d = mem_to_reg_in;
            rd_d         = rd_in;
            alu_result_d = alu_result_in;
            mem_data_d   = mem_data_in;
            if (valid_in) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            fresh_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            fresh_q      <= fresh_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            retired_q    <= retired_d;
        end
    end

`ifdef WB_SUBWORD_EN
    logic [1:0] load_size_q, load_size_d;
    logic       load_unsigned_q, load_unsigned_d;
    logic [1:0] byte_off_q, byte_off_d;

    always_comb begin
        load_size_d     = load_size_q;
        load_unsigned_d = load_unsigned_q;
        byte_off_d      = byte_off_q;
        if (capture) begin
            load_size_d     = load_size_in;
            load_unsigned_d = load_unsigned_in;
            byte_off_d      = byte_off_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_size_q     <= LS_WORD;
            load_unsigned_q <= 1'b0;
            byte_off_q      <= 2'd0;
        end else begin
            load_size_q     <= load_size_d;
            load_unsigned_q <= load_unsigned_d;
            byte_off_q      <= byte_off_d;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .load_size     (load_size_q),
        .load_unsigned (load_unsigned_q),
        .byte_off      (byte_off_q),
        .data_in       (mem_data_q),
        .data_out      (load_value)
    );
`else
    logic unused_subword;
    assign unused_subword = ^{load_size_in, load_unsigned_in, byte_off_in};
    assign load_value     = mem_data_q;
`endif

    // A stalled entry keeps valid_q but loses fresh_q, so it writes the register file once.
    assign r_write  = valid_q && fresh_q && reg_write_q && (rd_q != REG_ZERO);
    assign rd_write = rd_q;
    assign w_data   = mem_to_reg_q ? load_value : alu_result_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a vector table for the main behaviour plus
// hand-written sequences for reset, counter wrap and load extraction.
module tb_writeback_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic              reg_write_in;
    logic              mem_to_reg_in;
    logic [1:0]        load_size_in;
    logic              load_unsigned_in;
    logic [1:0]        byte_off_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] mem_data_in;
    logic [4:0]        rd_in;
    logic              r_write;
    logic [4:0]        rd_write;
    logic [DATA_W-1:0] w_data;
    logic [CNT_W-1:0]  retired;

    int n_tests;
    int n_fail;
    int exp_ret;

    writeback_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .valid_in         (valid_in),
        .reg_write_in     (reg_write_in),
        .mem_to_reg_in    (mem_to_reg_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .byte_off_in      (byte_off_in),
        .alu_result_in    (alu_result_in),
        .mem_data_in      (mem_data_in),
        .rd_in            (rd_in),
        .r_write          (r_write),
        .rd_write         (rd_write),
        .w_data           (w_data),
        .retired          (retired)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic [1:0]  byte_off;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        chk_data;
        logic        exp_r_write;
        logic [4:0]  exp_rd;
        logic [31:0] exp_w_data;
        logic [3:0]  exp_retired;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        stall            = 1'b0;
        flush            = 1'b0;
        valid_in         = 1'b0;
        reg_write_in     = 1'b0;
        mem_to_reg_in    = 1'b0;
        load_size_in     = 2'b00;
        load_unsigned_in = 1'b0;
        byte_off_in      = 2'b00;
        alu_result_in    = '0;
        mem_data_in      = '0;
        rd_in            = 5'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        stall            = v.stall;
        flush            = v.flush;
        valid_in         = v.valid;
        reg_write_in     = v.reg_write;
        mem_to_reg_in    = v.mem_to_reg;
        load_size_in     = v.load_size;
        load_unsigned_in = v.load_unsigned;
        byte_off_in      = v.byte_off;
        alu_result_in    = v.alu;
        mem_data_in      = v.mem;
        rd_in            = v.rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture one load of mem word w with the given size/sign/offset and check w_data.
    task automatic load_check(input string name, input logic [1:0] sz, input logic uns,
                              input logic [1:0] off, input logic [31:0] w, input logic [31:0] exp_w);
        drive_idle();
        valid_in         = 1'b1;
        reg_write_in     = 1'b1;
        mem_to_reg_in    = 1'b1;
        load_size_in     = sz;
        load_unsigned_in = uns;
        byte_off_in      = off;
        mem_data_in      = w;
        alu_result_in    = 32'h1357_9BDF;
        rd_in            = 5'd10;
        step();
        exp_ret = (exp_ret + 1) % 16;
        check(name, w_data, exp_w);
        check({name, "_rw"}, {31'd0, r_write}, 32'd1);
        check({name, "_ret"}, {28'd0, retired}, exp_ret);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_ret = 0;

        //       stl  fl  vld  rw  m2r  sz    uns  off   rd     alu            mem            chk  r   rd     w_data         ret
        vecs[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd5, 32'h0000_1234,32'h0,         1'b1,1'b1,5'd5, 32'h0000_1234,4'd1};
        vecs[1]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd7, 32'h0000_DEAD,32'h0,         1'b1,1'b0,5'd5, 32'h0000_1234,4'd1};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,5'd8, 32'h0000_BEEF,32'h0,         1'b1,1'b0,5'd5, 32'h0000_1234,4'd1};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,1'b0,2'b00,5'd9, 32'h0000_F00D,32'h0,         1'b1,1'b0,5'd5, 32'h0000_1234,4'd1};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,1'b0,2'b00,5'd31,32'h0000_0011,32'hCAFE_BABE, 1'b1,1'b1,5'd31,32'hCAFE_BABE,4'd2};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd3, 32'h0000_0033,32'h0,         1'b0,1'b0,5'd0, 32'h0,        4'd2};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd0, 32'h0000_0055,32'h0,         1'b1,1'b0,5'd0, 32'h0000_0055,4'd3};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,5'd9, 32'h0000_0077,32'h0,         1'b1,1'b0,5'd9, 32'h0000_0077,4'd3};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,5'd9, 32'h0000_0088,32'h0,         1'b1,1'b0,5'd9, 32'h0000_0088,4'd4};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd12,32'hFFFF_FFFF,32'h0,         1'b1,1'b1,5'd12,32'hFFFF_FFFF,4'd5};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd13,32'h0000_0099,32'h0,         1'b0,1'b0,5'd0, 32'h0,        4'd5};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,5'd1, 32'h0000_0000,32'h0,         1'b1,1'b1,5'd1, 32'h0000_0000,4'd6};

        drive_idle();
        rst = 1'b1;
        #2;
        check("reset_r_write", {31'd0, r_write}, 32'd0);
        check("reset_rd_write", {27'd0, rd_write}, 32'd0);
        check("reset_w_data", w_data, 32'd0);
        check("reset_retired", {28'd0, retired}, 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive_vec(vecs[i]);
            step();
            check($sformatf("vec%0d_r_write", i), {31'd0, r_write}, {31'd0, vecs[i].exp_r_write});
            check($sformatf("vec%0d_retired", i), {28'd0, retired}, {28'd0, vecs[i].exp_retired});
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_rd_write", i), {27'd0, rd_write}, {27'd0, vecs[i].exp_rd});
                check($sformatf("vec%0d_w_data", i), w_data, vecs[i].exp_w_data);
            end
        end

        // Reset asserted asynchronously in the middle of a stall.
        drive_idle();
        stall = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("midstall_rst_r_write", {31'd0, r_write}, 32'd0);
        check("midstall_rst_w_data", w_data, 32'd0);
        check("midstall_rst_rd_write", {27'd0, rd_write}, 32'd0);
        check("midstall_rst_retired", {28'd0, retired}, 32'd0);
        step();
        rst   = 1'b0;
        stall = 1'b0;
        exp_ret = 0;

        // First capture after reset, then 15 more: a 4-bit counter must come back to 0.
        for (int i = 0; i < 16; i++) begin
            drive_idle();
            valid_in      = 1'b1;
            reg_write_in  = 1'b1;
            rd_in         = 5'd4;
            alu_result_in = 32'h42 + i;
            step();
            exp_ret = (exp_ret + 1) % 16;
            check($sformatf("wrap%0d_retired", i), {28'd0, retired}, exp_ret);
        end
        check("wrap_back_to_zero", {28'd0, retired}, 32'd0);
        check("wrap_last_w_data", w_data, 32'h42 + 15);

`ifdef WB_SUBWORD_EN
        load_check("ld_byte_s_off2", 2'b01, 1'b0, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
        load_check("ld_half_u_off2", 2'b10, 1'b1, 2'd2, 32'h80FF_7F01, 32'h0000_80FF);
        load_check("ld_byte_s_off3", 2'b01, 1'b0, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
        load_check("ld_byte_u_off0", 2'b01, 1'b1, 2'd0, 32'h80FF_7F81, 32'h0000_0081);
        load_check("ld_half_s_off0", 2'b10, 1'b0, 2'd0, 32'h80FF_7F01, 32'h0000_7F01);
        load_check("ld_word_sz11", 2'b11, 1'b0, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01);
`else
        load_check("ld_ignore_byte", 2'b01, 1'b0, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
        load_check("ld_ignore_half", 2'b10, 1'b1, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
`endif

        drive_idle();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of datapath and register write data.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 stall  input  1  hold latched entry, ignore inputs.
REQ-007 flush  input  1  discard latched entry (insert bubble).
REQ-008 valid_in  input  1  memory stage presents an instruction.
REQ-009 reg_write_in  input  1  instruction writes a register.
REQ-010 mem_to_reg_in  input  1  1 = select memory data, 0 = select ALU result.
REQ-011 load_size_in  input  2  00 word, 01 byte, 10 halfword, 11 word.
REQ-012 load_unsigned_in  input  1  1 = zero-extend subword, 0 = sign-extend.
REQ-013 byte_off_in  input  2  address bits [1:0] of the load.
REQ-014 alu_result_in  input  DATA_W  ALU result from memory stage.
REQ-015 mem_data_in  input  DATA_W  data-memory read word.
REQ-016 rd_in  input  5  destination register index.
REQ-017 r_write  output  1  register-file write enable toward decode.
REQ-018 rd_write  output  5  register-file write index toward decode.
REQ-019 w_data  output  DATA_W  register-file write data toward decode.
REQ-020 retired  output  CNT_W  count of instructions captured into writeback.

Function
REQ-021 Latch SHALL capture all *_in fields on rising clk when !stall && !flush; one-cycle latency from inputs to r_write/rd_write/w_data.
REQ-022 flush SHALL clear the latched valid bit on the next edge; flush wins over stall when both asserted.
REQ-023 stall without flush SHALL hold every latched field unchanged.
REQ-024 A fresh bit SHALL be set on each capture with valid_in=1 and cleared on any edge where no new valid entry is captured.
REQ-025 r_write SHALL equal valid_q && fresh_q && reg_write_q && (rd_q != 0); a stalled entry writes exactly once.
REQ-026 rd_write SHALL equal rd_q; w_data SHALL be combinational from latched fields: mem_to_reg_q ? load_value : alu_result_q.
REQ-027 retired SHALL increment by 1 on every edge capturing valid_in=1 with !stall && !flush; wraps from 2^CNT_W-1 to 0.
REQ-028 Writes to register 0 SHALL still count in retired but never assert r_write.

Reset
REQ-029 rst SHALL immediately force valid_q=0, fresh_q=0, all latched fields 0, retired=0; hence r_write=0, rd_write=0, w_data=0.
REQ-030 rst asserted mid-stall or mid-flush SHALL override both; first capture after deassertion follows REQ-021.

Configuration
REQ-031 Macro WB_SUBWORD_EN defined: load_value SHALL extract byte k = bits [8k+7:8k] (k=byte_off_q) or halfword byte_off_q[1] ? [31:16] : [15:0], extended per load_unsigned_q; size 00/11 passes full word.
REQ-032 WB_SUBWORD_EN undefined: load_value SHALL equal mem_data_q; load_size_in, load_unsigned_in, byte_off_in ignored and not latched.

Structure
REQ-033 Shared package SHALL hold load-size encodings (LS_WORD, LS_BYTE, LS_HALF) and REG_ZERO constant.
REQ-034 Subword extraction SHALL live in sub-module load_align, instantiated only under WB_SUBWORD_EN.

Verification
REQ-035 Reset: rst=1 mid-run -> r_write=0, w_data=0, retired=0 same cycle.
REQ-036 ALU op: valid_in=1, reg_write_in=1, mem_to_reg_in=0, alu_result_in=0x0000_1234, rd_in=5 -> next cycle r_write=1, rd_write=5, w_data=0x0000_1234, retired=1.
REQ-037 Stall: capture as above then stall=1 for 3 cycles -> r_write=1 for first cycle only, rd_write/w_data held, retired unchanged.
REQ-038 Flush+stall together with valid entry latched -> next cycle r_write=0; rd_in=0 write -> r_write=0, retired increments.
REQ-039 WB_SUBWORD_EN: mem_data_in=0x80FF_7F01, byte load signed, byte_off=2 -> w_data=0xFFFF_FFFF; halfword unsigned, byte_off=2 -> 0x0000_80FF; byte signed, byte_off=3 -> 0xFFFF_FF80.
REQ-040 Counter wrap: CNT_W=4, 16 captures -> retired returns to 0.
